// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order completion marks, in-order commit.
// Precise exceptions stop commit at the faulting head entry and flush everything; branch flush squashes younger entries.
module rob_param #(
    parameter int  DEPTH  = 128,
    parameter int  WIDTH  = 4,
    parameter int  AREG_W = 5,
    parameter int  PREG_W = 8,
    parameter int  OP_W   = 11,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         alloc_valid,
    input  logic [WIDTH*AREG_W-1:0]  alloc_areg,
    input  logic [WIDTH*PREG_W-1:0]  alloc_preg,
    input  logic [WIDTH*OP_W-1:0]    alloc_op,
    output logic                     alloc_ready,
    output logic [IDX_W-1:0]         alloc_idx,
    input  logic [WIDTH-1:0]         exec_valid,
    input  logic [WIDTH*IDX_W-1:0]   exec_idx,
    input  logic                     exc_valid,
    input  logic [IDX_W-1:0]         exc_idx,
    input  logic                     flush_valid,
    input  logic [IDX_W-1:0]         flush_idx,
    output logic [WIDTH-1:0]         commit_valid,
    output logic [WIDTH*AREG_W-1:0]  commit_areg,
    output logic [WIDTH*PREG_W-1:0]  commit_preg,
    output logic [CNT_W-1:0]         commit_count,
    output logic                     exc_out,
    output logic [IDX_W-1:0]         exc_out_idx,
    output logic [IDX_W:0]           count,
    output logic                     empty,
    output logic                     full
);

    logic [DEPTH-1:0]            live_q, live_d, done_q, done_d, exc_q, exc_d;
    logic [IDX_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]              count_q, count_d;
    logic [AREG_W-1:0]           areg_q [DEPTH];
    logic [PREG_W-1:0]           preg_q [DEPTH];
    logic [DEPTH-1:0][OP_W-1:0]  op_q;

    logic [WIDTH-1:0]  acc_mask;
    logic [CNT_W-1:0]  acc_cnt, cmt_cnt;
    logic              acc_run, scan_run, exc_hit, flush_ok, alloc_we;
    logic [IDX_W-1:0]  exc_at, scan_idx, x_idx, a_idx, e_off, f_off;
    logic [IDX_W:0]    keep, cmt_ext;

    assign alloc_ready  = (count_q < (IDX_W+1)'(DEPTH - WIDTH));
    assign full         = ~alloc_ready;
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign alloc_idx    = tail_q;
    assign commit_count = cmt_cnt;
    assign exc_out      = exc_hit;
    assign exc_out_idx  = exc_at;

    // Opcode is held per entry for trace consumers; no port reads it back yet.
    logic unused_op;
    assign unused_op = ^op_q;

    always_comb begin
        acc_mask = '0;
        acc_cnt  = '0;
        acc_run  = alloc_ready;
        for (int i = 0; i < WIDTH; i++) begin
            acc_run     = acc_run & alloc_valid[i];
            acc_mask[i] = acc_run;
            if (acc_run) acc_cnt = acc_cnt + 1'b1;
        end
    end

    always_comb begin
        commit_valid = '0;
        commit_areg  = '0;
        commit_preg  = '0;
        cmt_cnt      = '0;
        exc_hit      = 1'b0;
        exc_at       = '0;
        scan_run     = 1'b1;
        scan_idx     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scan_idx = head_q + IDX_W'(i);
            if (scan_run && live_q[scan_idx] && done_q[scan_idx]) begin
                if (exc_q[scan_idx]) begin
                    exc_hit  = 1'b1;
                    exc_at   = scan_idx;
                    scan_run = 1'b0;
                end else begin
                    commit_valid[i]                    = 1'b1;
                    commit_areg[i*AREG_W +: AREG_W]    = areg_q[scan_idx];
                    commit_preg[i*PREG_W +: PREG_W]    = preg_q[scan_idx];
                    cmt_cnt                            = cmt_cnt + 1'b1;
                end
            end else begin
                scan_run = 1'b0;
            end
        end
    end

    always_comb begin
        live_d   = live_q;
        done_d   = done_q;
        exc_d    = exc_q;
        head_d   = head_q + IDX_W'(cmt_cnt);
        tail_d   = tail_q;
        count_d  = count_q;
        flush_ok = flush_valid && live_q[flush_idx];
        alloc_we = 1'b0;
        x_idx    = '0;
        a_idx    = '0;
        e_off    = '0;
        f_off    = flush_idx - head_q;
        keep     = (IDX_W+1)'(f_off) + 1'b1;
        cmt_ext  = (IDX_W+1)'(cmt_cnt);
        if (exc_hit) begin
            live_d  = '0;
            head_d  = exc_at + 1'b1;
            tail_d  = exc_at + 1'b1;
            count_d = '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                x_idx = exec_idx[i*IDX_W +: IDX_W];
                if (exec_valid[i] && live_q[x_idx]) done_d[x_idx] = 1'b1;
            end
            if (exc_valid && live_q[exc_idx]) exc_d[exc_idx] = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                if (commit_valid[i]) live_d[head_q + IDX_W'(i)] = 1'b0;
            end
            if (flush_ok) begin
                for (int e = 0; e < DEPTH; e++) begin
                    e_off = IDX_W'(e) - head_q;
                    if (e_off > f_off) live_d[e] = 1'b0;
                end
                // If commit already ran past the flush point the window is simply empty.
                if (keep < cmt_ext) begin
                    tail_d  = head_d;
                    count_d = '0;
                end else begin
                    tail_d  = flush_idx + 1'b1;
                    count_d = keep - cmt_ext;
                end
            end else begin
                alloc_we = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    if (acc_mask[i]) begin
                        a_idx         = tail_q + IDX_W'(i);
                        live_d[a_idx] = 1'b1;
                        done_d[a_idx] = 1'b0;
                        exc_d[a_idx]  = 1'b0;
                    end
                end
                tail_d  = tail_q + IDX_W'(acc_cnt);
                count_d = count_q + (IDX_W+1)'(acc_cnt) - cmt_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && alloc_we) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (acc_mask[i]) begin
                    areg_q[tail_q + IDX_W'(i)] <= alloc_areg[i*AREG_W +: AREG_W];
                    preg_q[tail_q + IDX_W'(i)] <= alloc_preg[i*PREG_W +: PREG_W];
                    op_q[tail_q + IDX_W'(i)]   <= alloc_op[i*OP_W +: OP_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=16, WIDTH=4): commit/exception scoreboard plus status checks.
module tb_rob_param;
    localparam int DEPTH = 16, WIDTH = 4, AREG_W = 5, PREG_W = 8, OP_W = 11, IDX_W = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [WIDTH-1:0]        alloc_valid;
    logic [WIDTH*AREG_W-1:0] alloc_areg;
    logic [WIDTH*PREG_W-1:0] alloc_preg;
    logic [WIDTH*OP_W-1:0]   alloc_op;
    logic                    alloc_ready;
    logic [IDX_W-1:0]        alloc_idx;
    logic [WIDTH-1:0]        exec_valid;
    logic [WIDTH*IDX_W-1:0]  exec_idx;
    logic                    exc_valid;
    logic [IDX_W-1:0]        exc_idx;
    logic                    flush_valid;
    logic [IDX_W-1:0]        flush_idx;
    logic [WIDTH-1:0]        commit_valid;
    logic [WIDTH*AREG_W-1:0] commit_areg;
    logic [WIDTH*PREG_W-1:0] commit_preg;
    logic [2:0]              commit_count;
    logic                    exc_out;
    logic [IDX_W-1:0]        exc_out_idx;
    logic [IDX_W:0]          count;
    logic                    empty;
    logic                    full;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int         exc_q[$];

    rob_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AREG_W(AREG_W), .PREG_W(PREG_W), .OP_W(OP_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_areg(alloc_areg), .alloc_preg(alloc_preg), .alloc_op(alloc_op),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .exec_valid(exec_valid), .exec_idx(exec_idx),
        .exc_valid(exc_valid), .exc_idx(exc_idx),
        .flush_valid(flush_valid), .flush_idx(flush_idx),
        .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_preg(commit_preg),
        .commit_count(commit_count), .exc_out(exc_out), .exc_out_idx(exc_out_idx),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Lane i carries preg = pbase+i and areg = low bits of that preg.
    task automatic do_alloc(input logic [3:0] mask, input logic [7:0] pbase);
        alloc_valid = mask;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_preg[i*PREG_W +: PREG_W] = pbase + 8'(i);
            alloc_areg[i*AREG_W +: AREG_W] = 5'(pbase + 8'(i));
            alloc_op[i*OP_W +: OP_W]       = 11'(i);
        end
        cyc();
        alloc_valid = '0;
    endtask

    task automatic do_exec(input logic [3:0] mask, input logic [3:0] i0, input logic [3:0] i1,
                           input logic [3:0] i2, input logic [3:0] i3);
        exec_valid = mask;
        exec_idx   = {i3, i2, i1, i0};
        cyc();
        exec_valid = '0;
    endtask

    task automatic push_range(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
    endtask

    // Monitor: every retiring lane and every exception is matched against the scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        int pc;
        if (reset === 1'b0 && (commit_valid != '0 || exc_out === 1'b1)) begin
            pc = 0;
            for (int i = 0; i < WIDTH; i++) begin
                if (commit_valid[i] === 1'b1) begin
                    pc++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: lane %0d preg %0d, expected no commit", i,
                                 commit_preg[i*PREG_W +: PREG_W]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_preg", int'(commit_preg[i*PREG_W +: PREG_W]), int'(e));
                        chk("commit_areg", int'(commit_areg[i*AREG_W +: AREG_W]), int'(e[4:0]));
                    end
                end
            end
            chk("commit_count_popcount", int'(commit_count), pc);
            chk("commit_contiguous", int'((commit_valid & (commit_valid + 4'd1)) == 4'd0), 1);
            if (exc_out === 1'b1) begin
                if (exc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_exc: idx %0d, expected no exception", exc_out_idx);
                end else begin
                    chk("exc_out_idx", int'(exc_out_idx), exc_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; alloc_valid = '0; alloc_areg = '0; alloc_preg = '0; alloc_op = '0;
        exec_valid = '0; exec_idx = '0; exc_valid = 1'b0; exc_idx = '0;
        flush_valid = 1'b0; flush_idx = '0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_alloc_ready", int'(alloc_ready), 1);
        chk("rst_commit_valid", int'(commit_valid), 0);
        chk("rst_commit_count", int'(commit_count), 0);
        chk("rst_exc_out", int'(exc_out), 0);
        chk("rst_alloc_idx", int'(alloc_idx), 0);

        // Basic allocation, partial lane mask, out-of-order completion.
        do_alloc(4'b1111, 8'h10);
        chk("a1_count", int'(count), 4);
        chk("a1_alloc_idx", int'(alloc_idx), 4);
        chk("a1_empty", int'(empty), 0);
        chk("a1_commit_valid", int'(commit_valid), 0);
        do_alloc(4'b1011, 8'h20);
        chk("a2_count", int'(count), 6);
        chk("a2_alloc_idx", int'(alloc_idx), 6);
        do_exec(4'b0111, 4'd1, 4'd2, 4'd3, 4'd0);
        chk("ooo_no_commit", int'(commit_valid), 0);
        push_range(8'h10, 4);
        do_exec(4'b0001, 4'd0, 4'd0, 4'd0, 4'd0);
        chk("ooo_commit_valid", int'(commit_valid), 15);
        chk("ooo_commit_count", int'(commit_count), 4);
        push_range(8'h20, 2);
        do_exec(4'b0011, 4'd4, 4'd5, 4'd0, 4'd0);
        chk("ooo_count_after", int'(count), 2);
        chk("lanes45_commit_valid", int'(commit_valid), 3);
        cyc();
        chk("drain1_count", int'(count), 0);
        chk("drain1_empty", int'(empty), 1);
        chk("drain1_alloc_idx", int'(alloc_idx), 6);

        // Fill to the DEPTH-WIDTH limit from head=6 so the window wraps.
        do_alloc(4'b1111, 8'h30);
        do_alloc(4'b1111, 8'h34);
        do_alloc(4'b1111, 8'h38);
        chk("full_count", int'(count), 12);
        chk("full_alloc_ready", int'(alloc_ready), 0);
        chk("full_full", int'(full), 1);
        chk("full_alloc_idx", int'(alloc_idx), 2);
        do_alloc(4'b1111, 8'h40);
        chk("full_ignored_count", int'(count), 12);
        chk("full_ignored_idx", int'(alloc_idx), 2);
        push_range(8'h30, 1);
        do_exec(4'b0001, 4'd6, 4'd0, 4'd0, 4'd0);
        chk("full_commit1_count", int'(commit_count), 1);
        cyc();
        chk("after1_count", int'(count), 11);
        chk("after1_alloc_ready", int'(alloc_ready), 1);
        chk("after1_full", int'(full), 0);
        push_range(8'h31, 11);
        do_exec(4'b1111, 4'd7, 4'd8, 4'd9, 4'd10);
        do_exec(4'b1111, 4'd11, 4'd12, 4'd13, 4'd14);
        do_exec(4'b0111, 4'd15, 4'd0, 4'd1, 4'd0);
        chk("wrap_commit_valid", int'(commit_valid), 7);
        cyc(); cyc();
        chk("wrap_count", int'(count), 0);
        chk("wrap_empty", int'(empty), 1);
        chk("wrap_alloc_idx", int'(alloc_idx), 2);

        // Reset with a concurrent allocation: reset wins.
        reset = 1'b1;
        do_alloc(4'b1111, 8'h99);
        reset = 1'b0;
        chk("midrst_count", int'(count), 0);
        chk("midrst_alloc_idx", int'(alloc_idx), 0);

        // Precise exception on entry 2; exec and exc hit entry 2 in the same cycle.
        do_alloc(4'b1111, 8'h50);
        do_alloc(4'b1111, 8'h54);
        chk("exc_pre_count", int'(count), 8);
        push_range(8'h50, 2);
        exc_q.push_back(2);
        exc_valid = 1'b1;
        exc_idx   = 4'd2;
        do_exec(4'b1111, 4'd0, 4'd1, 4'd2, 4'd3);
        exc_valid = 1'b0;
        chk("exc_commit_valid", int'(commit_valid), 3);
        chk("exc_out", int'(exc_out), 1);
        cyc();
        chk("exc_post_count", int'(count), 0);
        chk("exc_post_empty", int'(empty), 1);
        chk("exc_post_tail", int'(alloc_idx), 3);
        chk("exc_post_exc_out", int'(exc_out), 0);
        do_alloc(4'b0001, 8'h60);
        chk("exc_realloc_count", int'(count), 1);
        push_range(8'h60, 1);
        do_exec(4'b0001, 4'd3, 4'd0, 4'd0, 4'd0);
        chk("exc_head3_commit", int'(commit_valid), 1);
        cyc();
        chk("exc_final_count", int'(count), 0);
        chk("exc_final_tail", int'(alloc_idx), 4);

        // Branch flush at idx 4 with a same-cycle allocation that must be dropped.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_alloc(4'b1111, 8'h70);
        do_alloc(4'b1111, 8'h74);
        chk("fl_pre_count", int'(count), 8);
        flush_valid = 1'b1;
        flush_idx   = 4'd4;
        do_alloc(4'b1111, 8'h80);
        flush_valid = 1'b0;
        chk("fl_count", int'(count), 5);
        chk("fl_tail", int'(alloc_idx), 5);
        do_exec(4'b0001, 4'd6, 4'd0, 4'd0, 4'd0);
        chk("fl_dead_exec_count", int'(count), 5);
        chk("fl_dead_exec_commit", int'(commit_valid), 0);
        push_range(8'h70, 5);
        do_exec(4'b1111, 4'd0, 4'd1, 4'd2, 4'd3);
        chk("fl_commit_a", int'(commit_valid), 15);
        do_exec(4'b1111, 4'd4, 4'd5, 4'd6, 4'd7);
        chk("fl_commit_b", int'(commit_valid), 1);
        cyc(); cyc();
        chk("fl_final_count", int'(count), 0);
        chk("fl_final_empty", int'(empty), 1);
        chk("fl_final_tail", int'(alloc_idx), 5);

        chk("scoreboard_commits_left", exp_q.size(), 0);
        chk("scoreboard_exc_left", exc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer; next generation of the fixed 128-entry, 4-wide ROB.
- Generalised in depth and dispatch/commit width, with full/empty tracking and partial (branch) flush.
- Adds precise exception handling at commit, plus per-lane commit outputs that feed the rename free-list and the architectural map.
- Sits between rename/dispatch (allocation), the execution writeback ports (completion) and the commit/retire logic.

Parameters:
- DEPTH, 128, number of entries; power of two, >= 2*WIDTH.
- WIDTH, 4, number of allocate, execute and commit lanes.
- AREG_W, 5, architectural register index width.
- PREG_W, 8, physical register index width.
- OP_W, 11, opcode width.
- IDX_W, $clog2(DEPTH), entry index width (localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alloc_valid  in  WIDTH  per-lane allocate request.
- alloc_areg  in  WIDTH*AREG_W  packed; lane i at [i*AREG_W +: AREG_W].
- alloc_preg  in  WIDTH*PREG_W  packed per lane.
- alloc_op  in  WIDTH*OP_W  packed per lane.
- alloc_ready  out  1  ROB can accept a full WIDTH-lane group this cycle.
- alloc_idx  out  IDX_W  entry index given to lane 0; lane i gets alloc_idx+i mod DEPTH.
- exec_valid  in  WIDTH  completion marks.
- exec_idx  in  WIDTH*IDX_W  packed entry indices.
- exc_valid  in  1  mark an entry as faulting.
- exc_idx  in  IDX_W  faulting entry index.
- flush_valid  in  1  branch mispredict; squash entries younger than flush_idx.
- flush_idx  in  IDX_W  youngest surviving entry.
- commit_valid  out  WIDTH  per-lane retire this cycle; contiguous from lane 0.
- commit_areg  out  WIDTH*AREG_W  retiring architectural register.
- commit_preg  out  WIDTH*PREG_W  retiring physical register.
- commit_count  out  $clog2(WIDTH+1)  popcount of commit_valid.
- exc_out  out  1  oldest entry faulted; full flush happens at this edge.
- exc_out_idx  out  IDX_W  index of the faulting entry.
- count  out  IDX_W+1  live entries.
- empty  out  1  count==0.
- full  out  1  !alloc_ready.

Behaviour:
- Per-entry state: live, done, exc, areg, preg, op. Pointers head and tail are IDX_W wide and wrap modulo DEPTH. count is a register.
- Reset: head=tail=count=0 and all live/done/exc bits clear. After reset, commit_valid=0, commit_count=0, exc_out=0, empty=1, full=0, alloc_ready=1. A reset asserted mid-operation discards all entries in that cycle; every other input is ignored.
- alloc_ready = (count < DEPTH-WIDTH), so count never exceeds DEPTH-1.
- Accepted lanes: the leading run of ones in alloc_valid starting at lane 0. Lanes after the first zero are ignored. Nothing is accepted when alloc_ready=0.
- Accepted lane i writes entry tail+i with live=1, done=0, exc=0. tail advances by the accepted count.
- exec_valid[i] sets done on entry exec_idx[i] only if that entry is live at the start of the cycle; otherwise it is ignored. An index allocated in the same cycle is not live.
- exc_valid sets exc on exc_idx under the same liveness rule. exec and exc may target one entry in one cycle; both bits are set.
- Commit is combinational from registered state.
  - Scan entries head..head+WIDTH-1; stop at the first entry that is not live or not done.
  - An entry that is done with exc=0 is committed (commit_valid[lane]=1, with its areg/preg).
  - An entry that is done with exc=1 stops the scan, is not committed, and raises exc_out with exc_out_idx set to that entry.
- Edge update, commit: head += commit_count; committed entries are cleared to not live.
- Edge update, exc_out=1: full flush. head=tail=exc_out_idx+1 (the oldest slot after the fault), count=0, all live bits clear. Allocation, flush, exec and exc inputs that cycle are dropped. Entries older than the fault still commit that cycle.
- Edge update, flush_valid with exc_out=0 and flush_idx live:
  - Entries strictly younger than flush_idx become not live.
  - tail = flush_idx+1 and count = (tail_new - head_next) mod DEPTH.
  - Same-cycle allocation is dropped; same-cycle commits of older entries still happen.
- flush_valid with flush_idx not live is ignored.
- Otherwise count_next = count + accepted - commit_count.
- Latency: an entry allocated at edge N and marked done at edge M (M>N) drives commit_valid in the cycle after M, provided all older entries are done. head advances at edge M+1.
- Wrap-around: all index arithmetic is modulo DEPTH. Commit and allocation groups may straddle entry DEPTH-1 to entry 0.

Test Plan:
- Reset, then alloc_valid=4'b1111 for 1 cycle -> count=4, alloc_idx 0->4, empty=0, commit_valid=0.
- alloc_valid=4'b1011 -> only lanes 0 and 1 accepted; count +2, tail +2.
- Mark entries 1, 2, 3 done, then entry 0 done -> no commit until entry 0 is done; the cycle after, commit_valid=4'b1111, commit_count=4, with preg values in lane order.
- DEPTH=16, WIDTH=4: allocate 4+4+4 -> count=12, alloc_ready=0, full=1. A further alloc_valid=4'b1111 is ignored (count stays 12). Commit 1 -> count=11, alloc_ready=1.
- 8 live entries (idx 0..7); exc on 2; done on 0..3 -> commit_valid=4'b0011 and exc_out=1 with exc_out_idx=2 -> next cycle count=0, head=tail=3, empty=1.
- 8 live entries; flush_valid with flush_idx=4 plus alloc_valid=4'b1111 in the same cycle -> tail=5, count=5, allocation dropped. Exec on idx 6 the next cycle is ignored (idx 6 is not live).
